fc_l2_arbiter: RTL

FC_L2_ARBITER -- requirements
Module: fc_l2_arbiter

---
 rtl/fc_l2_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fc_l2_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM port among NB_MASTERS requesters.
// The grant path is combinational. An in-order FIFO of granted master indices
// routes each L2 response back to the master that issued the request.
module fc_l2_arbiter #(
    parameter int NB_MASTERS      = 2,
    parameter int MAX_OUTSTANDING = 2,
    localparam int IDX_W = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1,
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NB_MASTERS-1:0]       m_req_i,
    input  logic [NB_MASTERS-1:0][31:0] m_add_i,
    input  logic [NB_MASTERS-1:0]       m_wen_i,
    input  logic [NB_MASTERS-1:0][31:0] m_wdata_i,
    input  logic [NB_MASTERS-1:0][3:0]  m_be_i,
    output logic [NB_MASTERS-1:0]       m_gnt_o,
    output logic [NB_MASTERS-1:0]       m_r_valid_o,
    output logic [31:0]                 m_r_rdata_o,
    output logic                        m_r_opc_o,
    output logic                        s_req_o,
    output logic [31:0]                 s_add_o,
    output logic                        s_wen_o,
    output logic [31:0]                 s_wdata_o,
    output logic [3:0]                  s_be_o,
    input  logic                        s_gnt_i,
    input  logic                        s_r_valid_i,
    input  logic [31:0]                 s_r_rdata_i,
    input  logic                        s_r_opc_i,
    output logic [CNT_W-1:0]            outstanding_o,
    output logic                        busy_o,
    output logic                        err_orphan_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             orphan_q, orphan_d;
    logic             any_req, full, push, pop;

    assign any_req = |m_req_i;
    assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign s_req_o = any_req & ~full;
    assign push    = s_req_o & s_gnt_i;
    assign pop     = s_r_valid_i & (cnt_q != '0);

    // Pick the first requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic [IDX_W:0] j;
        logic           found;
        sel   = rr_ptr_q;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NB_MASTERS; i++) begin
            j = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (j >= (IDX_W+1)'(NB_MASTERS)) j = j - (IDX_W+1)'(NB_MASTERS);
            if (!found && m_req_i[j[IDX_W-1:0]]) begin
                sel   = j[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Request mux, grant steering and response routing.
    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        s_add_o     = '0;
        s_wen_o     = 1'b1;
        s_wdata_o   = '0;
        s_be_o      = '0;
        if (any_req) begin
            s_add_o   = m_add_i[sel];
            s_wen_o   = m_wen_i[sel];
            s_wdata_o = m_wdata_i[sel];
            s_be_o    = m_be_i[sel];
        end
        m_gnt_o[sel]                  = push;
        m_r_valid_o[fifo_q[rd_ptr_q]] = pop;
    end

    assign m_r_rdata_o   = s_r_rdata_i;
    assign m_r_opc_o     = s_r_opc_i;
    assign outstanding_o = cnt_q;
    assign busy_o        = (cnt_q != '0);
    assign err_orphan_o  = orphan_q;

    // Next-state for round-robin pointer, tracker pointers/count and orphan flag.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        orphan_d = orphan_q | (s_r_valid_i & (cnt_q == '0));
        if (push) begin
            rr_ptr_d = (sel == IDX_W'(NB_MASTERS - 1)) ? '0 : sel + 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    // State registers; reset discards every tracked transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            if (push) fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule
